add_digit_serial: RTL and testbench

- Parametrised, multi-cycle successor to the 4-bit combinational adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, through a registered carry chain.
- Uses a valid/ready handshake on input and on output.
- Sits in arithmetic datapaths where area beats latency; a WIDTH=DIGIT=4 build reproduces the 4-bit adder results.

---
 rtl/add_pkg.sv | 17 +
 rtl/add_digit.sv | 28 ++
 rtl/add_digit_serial.sv | 112 +++++++++++
 tb/tb_add_digit_serial.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared types and helpers for the digit-serial adder.
package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational ripple of DIGIT full adders; also reports the carry into the top bit.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/add_digit_serial.sv
// Digit-serial add/subtract: one DIGIT-bit slice per clock through a registered carry.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and s/cy_out/ovf hold while out_valid.
module add_digit_serial
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cy_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cy_out,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_c_msb;
  int               base;

  // y is stored already inverted for subtract, so the datapath only ever adds.
  always_comb begin
    base  = int'(cnt) * DIGIT;
    dig_a = x_q[base +: DIGIT];
    dig_b = y_q[base +: DIGIT];
  end

  add_digit #(.DIGIT(DIGIT)) u_add_digit (
    .a     (dig_a),
    .b     (dig_b),
    .ci    (carry),
    .sum   (dig_sum),
    .co    (dig_co),
    .c_msb (dig_c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      cy_out    <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= x;
            y_q      <= y ^ {WIDTH{sub}};
            carry    <= cy_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          s[base +: DIGIT] <= dig_sum;
          carry            <= dig_co;
          cnt              <= cnt + 1'b1;
          if (cnt == LAST) begin
            cy_out    <= dig_co;
            ovf       <= dig_c_msb ^ dig_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_add_digit_serial.sv
// Directed bench: 16/4 serial build plus a 4/4 single-cycle regression build.
module tb_add_digit_serial;
  import add_pkg::*;

  int checks;
  int failures;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit, 4-bit digits
  logic        in_valid, in_ready, cy_in, sub, out_valid, out_ready, cy_out, ovf;
  logic [15:0] x, y, s;
  state_t      st;

  add_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cy_in(cy_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cy_out(cy_out), .ovf(ovf), .dbg_state(st)
  );

  // 4-bit regression build
  logic       in_valid4, in_ready4, cy_in4, sub4, out_valid4, out_ready4, cy_out4, ovf4;
  logic [3:0] x4, y4, s4;
  state_t     st4;

  add_digit_serial #(.WIDTH(4), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x4), .y(y4), .cy_in(cy_in4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cy_out(cy_out4), .ovf(ovf4), .dbg_state(st4)
  );

  // driver tasks
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic sb, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    x = a; y = b; cy_in = c; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom_range(0, 65535); y = $urandom_range(0, 65535);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b,
                        input logic c, output int lat);
    x4 = a; y4 = b; cy_in4 = c; sub4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 16'h0 || cy_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || st !== IDLE) begin
      failures++;
      $display("FAIL reset_state: s=%h cy=%b ovf=%b ov=%b ir=%b st=%0d, want 0/0/0/0/1/IDLE",
               s, cy_out, ovf, out_valid, in_ready, st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_add(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    issue(a, b, c, sb, lat);
    checks++;
    if (lat !== 4 || s !== es || cy_out !== ec || ovf !== eo) begin
      failures++;
      $display("FAIL %s: lat=%0d s=%h cy=%b ovf=%b, want lat=4 s=%h cy=%b ovf=%b",
               name, lat, s, cy_out, ovf, es, ec, eo);
    end
    release_result();
  endtask

  task automatic test_add();
    run_add("add_basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_add("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    run_add("sub_pos",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_add("sub_neg",   16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_add("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_add("sub_borrow",16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
  endtask

  task automatic test_handshake();
    int lat;
    logic stable_ok;
    int guard;
    // accept, then pulse in_valid with other operands during RUN
    x = 16'h1111; y = 16'h2222; cy_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    x = 16'hAAAA; y = 16'h0F0F; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (s !== 16'h3333 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL hs_ignore_in_valid: s=%h ov=%b, want 3333 1", s, out_valid);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (s !== 16'h3333 || in_ready !== 1'b0 || out_valid !== 1'b1 || st !== DONE)
        stable_ok = 1'b0;
    end
    checks++;
    if (stable_ok !== 1'b1) begin
      failures++;
      $display("FAIL hs_hold_done: last s=%h ir=%b ov=%b, want 3333 0 1", s, in_ready, out_valid);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || st !== IDLE || s !== 16'h3333) begin
      failures++;
      $display("FAIL hs_release: ov=%b ir=%b st=%0d s=%h, want 0 1 IDLE 3333",
               out_valid, in_ready, st, s);
    end
    // back-to-back issue after release
    issue(16'h0010, 16'h0020, 1'b1, 1'b0, lat);
    checks++;
    if (lat !== 4 || s !== 16'h0031) begin
      failures++;
      $display("FAIL back_to_back: lat=%0d s=%h, want 4 0031", lat, s);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    x = 16'hFFFF; y = 16'hFFFF; cy_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (s !== 16'h0 || cy_out !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 ||
        in_ready !== 1'b1 || st !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_run: s=%h cy=%b ovf=%b ov=%b ir=%b st=%0d, want 0/0/0/0/1/IDLE",
               s, cy_out, ovf, out_valid, in_ready, st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 4 || s !== 16'h5555 || cy_out !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_add: lat=%0d s=%h cy=%b ovf=%b, want 4 5555 0 0",
               lat, s, cy_out, ovf);
    end
    release_result();
  endtask

  task automatic run4(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic c, input logic [3:0] es, input logic ec, input logic eo);
    int lat;
    issue4(a, b, c, lat);
    checks++;
    if (lat !== 1 || s4 !== es || cy_out4 !== ec || ovf4 !== eo) begin
      failures++;
      $display("FAIL %s: lat=%0d s=%b cy=%b ovf=%b, want lat=1 s=%b cy=%b ovf=%b",
               name, lat, s4, cy_out4, ovf4, es, ec, eo);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_width4();
    run4("w4_15_15_1", 4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0);
    run4("w4_12_5",    4'd12, 4'd5,  1'b0, 4'b0001, 1'b1, 1'b0);
    run4("w4_3_4_1",   4'd3,  4'd4,  1'b1, 4'b1000, 1'b0, 1'b1);
    run4("w4_8_8",     4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1);
    run4("w4_10_5",    4'd10, 4'd5,  1'b0, 4'b1111, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0;
    in_valid = 1'b0; x = '0; y = '0; cy_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; x4 = '0; y4 = '0; cy_in4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_handshake();
    test_reset_mid_run();
    test_width4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
